// File: rtl/fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter
//
// This block lets the instruction fetch unit (IF) and the load/store unit
// (DATA) share the core's single memory request port.
//
// - Requests are granted combinationally, at most one per cycle. DATA has
//   priority, but a starvation counter forces an IF grant after
//   P_STARVE_LIMIT consecutive DATA grants while IF is waiting.
// - The granted request is registered into a one-entry stage that drives
//   the shared port.
// - Each issued request pushes its owner into an in-order tag queue. The
//   queue routes responses back to the requester that issued them.
// - iIF_FLUSH invalidates every in-flight fetch, whether staged or queued.
//   DATA traffic is not affected.
//
// Ports
//   iCLOCK, iRESET                clock, asynchronous active-high reset
//   iIF_*  / oIF_LOCK             fetch request channel (valid/lock handshake)
//   iIF_FLUSH                     drop all pending fetch work
//   oIF_VALID/PAGEFAULT/DATA      fetch response, one-cycle valid pulse
//   iDATA_* / oDATA_LOCK          load/store request channel
//   oDATA_VALID/PAGEFAULT/DATA    load/store response, one-cycle valid pulse
//   oMEM_* / iMEM_LOCK            shared request port (registered payload)
//   iMEM_VALID/PAGEFAULT/DATA     in-order memory responses
//   oPROTOCOL_ERR                 sticky: response arrived with no request
//                                 outstanding
// -----------------------------------------------------------------------------
module fetch_mem_arbiter #(
  parameter int P_TAG_DEPTH    = 8,
  parameter int P_TAG_DEPTH_N  = 3,
  parameter int P_STARVE_LIMIT = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  // fetch request / response
  input  logic        iIF_REQ,
  output logic        oIF_LOCK,
  input  logic [1:0]  iIF_MMUMOD,
  input  logic [31:0] iIF_ADDR,
  input  logic        iIF_FLUSH,
  output logic        oIF_VALID,
  output logic        oIF_PAGEFAULT,
  output logic [31:0] oIF_DATA,
  // load/store request / response
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic        iDATA_RW,
  input  logic [3:0]  iDATA_MASK,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  output logic        oDATA_VALID,
  output logic        oDATA_PAGEFAULT,
  output logic [31:0] oDATA_DATA,
  // shared memory port
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [3:0]  oMEM_MASK,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic        iMEM_PAGEFAULT,
  input  logic [31:0] iMEM_DATA,
  output logic        oPROTOCOL_ERR
);

  localparam int   L_CNT_W    = P_TAG_DEPTH_N + 1;
  localparam int   L_OCC_W    = P_TAG_DEPTH_N + 2;
  localparam int   L_STARVE_W = $clog2(P_STARVE_LIMIT + 1);
  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // stage register (one request waiting for the shared port)
  logic                     b_out_valid;
  logic                     b_out_owner;
  logic                     b_out_rw;
  logic [3:0]               b_out_mask;
  logic [1:0]               b_out_mmumod;
  logic [31:0]              b_out_addr;
  logic [31:0]              b_out_data;

  // in-order tag queue, one owner bit and one live bit per entry
  logic [P_TAG_DEPTH-1:0]   tag_owner_reg;
  logic [P_TAG_DEPTH-1:0]   tag_owner_next;
  logic [P_TAG_DEPTH-1:0]   tag_live_reg;
  logic [P_TAG_DEPTH-1:0]   tag_live_next;
  logic [P_TAG_DEPTH_N-1:0] wr_ptr_reg;
  logic [P_TAG_DEPTH_N-1:0] rd_ptr_reg;
  logic [L_CNT_W-1:0]       tag_count_reg;

  logic [L_STARVE_W-1:0]    b_starve;

  // ---------------------------------------------------------------------------
  // Issue / pop / acceptance
  // ---------------------------------------------------------------------------
  logic               issue;
  logic               pop;
  logic               stray_resp;
  logic               stage_free;
  logic [L_OCC_W-1:0] occupancy;
  logic               can_accept;
  logic               starved;
  logic               if_wins;
  logic               grant_if;
  logic               grant_data;
  logic               head_owner;
  logic               head_live;

  assign issue      = b_out_valid && !iMEM_LOCK;
  assign pop        = iMEM_VALID && (tag_count_reg != '0);
  assign stray_resp = iMEM_VALID && (tag_count_reg == '0);
  assign stage_free = !b_out_valid || !iMEM_LOCK;

  // Every request counts against the depth from the time it is staged until
  // its response pops. The staged entry moves into the queue when it issues,
  // so issuing does not free anything. A pop in the same cycle does free a
  // slot, and that slot can be reused at once.
  assign occupancy  = L_OCC_W'(tag_count_reg) + L_OCC_W'(b_out_valid) - L_OCC_W'(pop);
  assign can_accept = stage_free && (occupancy < L_OCC_W'(P_TAG_DEPTH)) && !iRESET;

  // IF wins only if it is not being flushed. When it is flushed, the slot
  // goes to DATA.
  assign starved    = (b_starve == L_STARVE_W'(P_STARVE_LIMIT));
  assign if_wins    = iIF_REQ && !iIF_FLUSH && (starved || !iDATA_REQ);
  assign grant_if   = can_accept && if_wins;
  assign grant_data = can_accept && iDATA_REQ && !if_wins;

  assign oIF_LOCK   = !grant_if;
  assign oDATA_LOCK = !grant_data;

  // shared port is driven straight from the stage
  assign oMEM_REQ    = b_out_valid;
  assign oMEM_RW     = b_out_rw;
  assign oMEM_MASK   = b_out_mask;
  assign oMEM_MMUMOD = b_out_mmumod;
  assign oMEM_ADDR   = b_out_addr;
  assign oMEM_DATA   = b_out_data;

  assign head_owner = tag_owner_reg[rd_ptr_reg];
  assign head_live  = tag_live_reg[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Per-entry next state of the tag queue
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < P_TAG_DEPTH; gi++) begin : g_tag
      logic push_here;
      assign push_here = issue && (wr_ptr_reg == P_TAG_DEPTH_N'(gi));
      assign tag_owner_next[gi] = push_here ? b_out_owner : tag_owner_reg[gi];
      // An IF request that issues during a flush is queued as dead, so its
      // response is dropped like those of the older fetches.
      assign tag_live_next[gi]  = push_here
                                ? ((b_out_owner == OWNER_DATA) || !iIF_FLUSH)
                                : (tag_live_reg[gi] &&
                                   !(iIF_FLUSH && (tag_owner_reg[gi] == OWNER_IF)));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      b_out_valid     <= 1'b0;
      b_out_owner     <= OWNER_IF;
      b_out_rw        <= 1'b0;
      b_out_mask      <= 4'h0;
      b_out_mmumod    <= 2'h0;
      b_out_addr      <= 32'h0;
      b_out_data      <= 32'h0;
      tag_owner_reg   <= '0;
      tag_live_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tag_count_reg   <= '0;
      b_starve        <= '0;
      oIF_VALID       <= 1'b0;
      oIF_PAGEFAULT   <= 1'b0;
      oIF_DATA        <= 32'h0;
      oDATA_VALID     <= 1'b0;
      oDATA_PAGEFAULT <= 1'b0;
      oDATA_DATA      <= 32'h0;
      oPROTOCOL_ERR   <= 1'b0;
    end else begin
      // ---- stage register ----
      if (grant_if) begin
        b_out_valid  <= 1'b1;
        b_out_owner  <= OWNER_IF;
        b_out_rw     <= 1'b0;
        b_out_mask   <= 4'hF;
        b_out_mmumod <= iIF_MMUMOD;
        b_out_addr   <= iIF_ADDR;
        b_out_data   <= 32'h0;
      end else if (grant_data) begin
        b_out_valid  <= 1'b1;
        b_out_owner  <= OWNER_DATA;
        b_out_rw     <= iDATA_RW;
        b_out_mask   <= iDATA_MASK;
        b_out_mmumod <= iDATA_MMUMOD;
        b_out_addr   <= iDATA_ADDR;
        b_out_data   <= iDATA_DATA;
      end else if (issue) begin
        b_out_valid  <= 1'b0;
      end else if (iIF_FLUSH && b_out_valid && (b_out_owner == OWNER_IF)) begin
        // a fetch still stuck behind iMEM_LOCK is simply withdrawn
        b_out_valid  <= 1'b0;
      end

      // ---- tag queue ----
      tag_owner_reg <= tag_owner_next;
      tag_live_reg  <= tag_live_next;
      if (issue) begin
        wr_ptr_reg <= (wr_ptr_reg == P_TAG_DEPTH_N'(P_TAG_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == P_TAG_DEPTH_N'(P_TAG_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({issue, pop})
        2'b10:   tag_count_reg <= tag_count_reg + 1'b1;
        2'b01:   tag_count_reg <= tag_count_reg - 1'b1;
        default: tag_count_reg <= tag_count_reg;
      endcase

      // ---- starvation counter ----
      if (grant_if || !iIF_REQ) begin
        b_starve <= '0;
      end else if (grant_data && !starved) begin
        b_starve <= b_starve + 1'b1;
      end

      // ---- response routing ----
      oIF_VALID   <= 1'b0;
      oDATA_VALID <= 1'b0;
      if (pop) begin
        if (head_owner == OWNER_DATA) begin
          oDATA_VALID     <= 1'b1;
          oDATA_PAGEFAULT <= iMEM_PAGEFAULT;
          oDATA_DATA      <= iMEM_DATA;
        end else if (head_live && !iIF_FLUSH) begin
          oIF_VALID       <= 1'b1;
          oIF_PAGEFAULT   <= iMEM_PAGEFAULT;
          oIF_DATA        <= iMEM_DATA;
        end
      end

      if (stray_resp) begin
        oPROTOCOL_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fetch_mem_arbiter
//
// Directed testbench for fetch_mem_arbiter. Each task covers one scenario and
// compares the DUT outputs against expected values worked out by hand.
// Inputs are driven 1 ns after the rising edge. Combinational locks are
// sampled 1 ns after that. Registered outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_lock, if_flush, if_valid, if_pf;
  logic [1:0]  if_mmumod;
  logic [31:0] if_addr, if_data;
  logic        data_req, data_lock, data_rw, data_valid, data_pf;
  logic [3:0]  data_mask;
  logic [1:0]  data_mmumod;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_lock, mem_rw, mem_valid, mem_pf, proto_err;
  logic [3:0]  mem_mask;
  logic [1:0]  mem_mmumod;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_mem_arbiter dut (
    .iCLOCK(clk),            .iRESET(rst),
    .iIF_REQ(if_req),        .oIF_LOCK(if_lock),          .iIF_MMUMOD(if_mmumod),
    .iIF_ADDR(if_addr),      .iIF_FLUSH(if_flush),        .oIF_VALID(if_valid),
    .oIF_PAGEFAULT(if_pf),   .oIF_DATA(if_data),
    .iDATA_REQ(data_req),    .oDATA_LOCK(data_lock),      .iDATA_RW(data_rw),
    .iDATA_MASK(data_mask),  .iDATA_MMUMOD(data_mmumod),  .iDATA_ADDR(data_addr),
    .iDATA_DATA(data_wdata), .oDATA_VALID(data_valid),    .oDATA_PAGEFAULT(data_pf),
    .oDATA_DATA(data_rdata),
    .oMEM_REQ(mem_req),      .iMEM_LOCK(mem_lock),        .oMEM_RW(mem_rw),
    .oMEM_MASK(mem_mask),    .oMEM_MMUMOD(mem_mmumod),    .oMEM_ADDR(mem_addr),
    .oMEM_DATA(mem_wdata),   .iMEM_VALID(mem_valid),      .iMEM_PAGEFAULT(mem_pf),
    .iMEM_DATA(mem_rdata),   .oPROTOCOL_ERR(proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_mmumod = 2'd0; if_addr = 32'h0; if_flush = 1'b0;
    data_req = 1'b0; data_rw = 1'b0; data_mask = 4'h0; data_mmumod = 2'd0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_lock = 1'b0; mem_valid = 1'b0; mem_pf = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    if_req = 1'b1; data_req = 1'b1;
    step();
    checks++; if (if_lock !== 1'b1) begin errors++; $display("FAIL reset_if_lock: got %b expected 1", if_lock); end
    checks++; if (data_lock !== 1'b1) begin errors++; $display("FAIL reset_data_lock: got %b expected 1", data_lock); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (if_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got if=%b data=%b expected 0/0", if_valid, data_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
    rst = 1'b0;
    idle_inputs();
    $display("reset: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_if_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(4 * i); if_mmumod = 2'd1;
      #1;
      checks++; if (if_lock !== 1'b0) begin errors++; $display("FAIL if_stream_lock[%0d]: got %b expected 0", i, if_lock); end
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin errors++; $display("FAIL if_stream_issue[%0d]: got req=%b addr=%h expected 1/%h", i, mem_req, mem_addr, 32'(4 * i)); end
      checks++; if (mem_rw !== 1'b0 || mem_mask !== 4'hF || mem_mmumod !== 2'd1) begin errors++; $display("FAIL if_stream_payload[%0d]: got rw=%b mask=%h mmu=%0d expected 0/f/1", i, mem_rw, mem_mask, mem_mmumod); end
      $display("if_stream: issued addr %h", mem_addr);
    end
    if_req = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL if_stream_drain: got %b expected 0", mem_req); end
    for (int j = 0; j < 3; j++) begin
      mem_valid = 1'b1; mem_rdata = 32'hA0 + 32'(j);
      step();
      checks++; if (if_valid !== 1'b1 || if_data !== 32'hA0 + 32'(j) || data_valid !== 1'b0) begin errors++; $display("FAIL if_stream_resp[%0d]: got if_valid=%b data=%h data_valid=%b expected 1/%h/0", j, if_valid, if_data, data_valid, 32'hA0 + 32'(j)); end
      $display("if_stream: response %h", if_data);
    end
    mem_valid = 1'b0;
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL if_stream_pulse: got %b expected 0", if_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL if_stream_proto: got %b expected 0", proto_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    logic exp_if;
    logic exp_resp_if;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if_req = 1'b1; if_addr = 32'h1000 + 32'(c);
      data_req = 1'b1; data_addr = 32'h2000 + 32'(c);
      mem_valid = (c >= 2); mem_rdata = 32'(c);
      #1;
      exp_if = ((c % 5) == 4);
      checks++; if (if_lock !== !exp_if || data_lock !== exp_if) begin errors++; $display("FAIL starve_grant[%0d]: got if_lock=%b data_lock=%b expected %b/%b", c, if_lock, data_lock, !exp_if, exp_if); end
      step();
      if (c >= 2) begin
        // response in cycle c belongs to the grant from cycle c-2
        exp_resp_if = (((c - 2) % 5) == 4);
        checks++; if (if_valid !== exp_resp_if || data_valid !== !exp_resp_if) begin errors++; $display("FAIL starve_route[%0d]: got if=%b data=%b expected %b/%b", c, if_valid, data_valid, exp_resp_if, !exp_resp_if); end
      end
      $display("starve: cycle %0d if_granted=%b", c, exp_if);
    end
    idle_inputs();
    step();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL starve_proto: got %b expected 0", proto_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      data_req = 1'b1; data_addr = 32'h300 + 32'(4 * c);
      #1;
      checks++; if (data_lock !== 1'b0) begin errors++; $display("FAIL full_accept[%0d]: got %b expected 0", c, data_lock); end
      step();
    end
    for (int c = 8; c < 11; c++) begin
      data_req = 1'b1; if_req = 1'b1;
      #1;
      checks++; if (data_lock !== 1'b1 || if_lock !== 1'b1) begin errors++; $display("FAIL full_locked[%0d]: got data_lock=%b if_lock=%b expected 1/1", c, data_lock, if_lock); end
      step();
    end
    if_req = 1'b0; data_req = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h77;
    #1;
    checks++; if (data_lock !== 1'b0) begin errors++; $display("FAIL full_reuse: got %b expected 0", data_lock); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b1 || data_rdata !== 32'h77) begin errors++; $display("FAIL full_resp: got valid=%b data=%h expected 1/77", data_valid, data_rdata); end
    checks++; if (data_lock !== 1'b1) begin errors++; $display("FAIL full_one_more: got %b expected 1", data_lock); end
    step();
    #1;
    checks++; if (data_lock !== 1'b1) begin errors++; $display("FAIL full_still: got %b expected 1", data_lock); end
    $display("full: single slot reused");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++; if (if_lock !== 1'b0) begin errors++; $display("FAIL flush_if0_lock: got %b expected 0", if_lock); end
    step();
    if_req = 1'b0; data_req = 1'b1; data_addr = 32'h100; data_rw = 1'b0; data_mask = 4'hF;
    #1;
    checks++; if (data_lock !== 1'b0) begin errors++; $display("FAIL flush_data_lock: got %b expected 0", data_lock); end
    step();
    data_req = 1'b0; if_req = 1'b1; if_addr = 32'h14;
    #1;
    checks++; if (if_lock !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL flush_if1: got lock=%b addr=%h expected 0/100", if_lock, mem_addr); end
    step();
    if_req = 1'b1; if_addr = 32'h18; if_flush = 1'b1;
    #1;
    checks++; if (if_lock !== 1'b1) begin errors++; $display("FAIL flush_blocks_if: got %b expected 1", if_lock); end
    checks++; if (mem_addr !== 32'h14 || mem_req !== 1'b1) begin errors++; $display("FAIL flush_stage: got req=%b addr=%h expected 1/14", mem_req, mem_addr); end
    step();
    if_req = 1'b0; if_flush = 1'b0;
    step();
    for (int j = 0; j < 3; j++) begin
      mem_valid = 1'b1; mem_rdata = 32'h11 * 32'(j + 1);
      step();
      checks++; if (if_valid !== 1'b0 || data_valid !== (j == 1)) begin errors++; $display("FAIL flush_resp[%0d]: got if=%b data=%b expected 0/%b", j, if_valid, data_valid, (j == 1)); end
      if (j == 1) begin
        checks++; if (data_rdata !== 32'h22) begin errors++; $display("FAIL flush_data: got %h expected 22", data_rdata); end
      end
      $display("flush: response %0d routed if=%b data=%b", j, if_valid, data_valid);
    end
    mem_valid = 1'b0;
    step();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL flush_proto: got %b expected 0", proto_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_staged();
    do_reset();
    mem_lock = 1'b1; if_req = 1'b1; if_addr = 32'h20;
    #1;
    checks++; if (if_lock !== 1'b0) begin errors++; $display("FAIL flush_staged_lock: got %b expected 0", if_lock); end
    step();
    if_req = 1'b0; if_flush = 1'b1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_staged_held: got %b expected 1", mem_req); end
    step();
    if_flush = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_staged_drop: got %b expected 0", mem_req); end
    mem_lock = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_staged_gone: got %b expected 0", mem_req); end
    $display("flush_staged: staged fetch withdrawn");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mem_lock();
    do_reset();
    mem_lock = 1'b1;
    data_req = 1'b1; data_rw = 1'b1; data_addr = 32'h200; data_wdata = 32'hDEAD;
    data_mask = 4'h3; data_mmumod = 2'd2;
    #1;
    checks++; if (data_lock !== 1'b0) begin errors++; $display("FAIL lock_first_accept: got %b expected 0", data_lock); end
    step();
    for (int k = 0; k < 3; k++) begin
      data_req = 1'b1; data_rw = 1'b0; data_addr = 32'h204; data_wdata = 32'hBEEF;
      mem_lock = 1'b1;
      #1;
      checks++; if (data_lock !== 1'b1) begin errors++; $display("FAIL lock_held_lock[%0d]: got %b expected 1", k, data_lock); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD || mem_rw !== 1'b1 || mem_mask !== 4'h3 || mem_mmumod !== 2'd2) begin
        errors++; $display("FAIL lock_stable[%0d]: got req=%b addr=%h data=%h rw=%b mask=%h mmu=%0d expected 1/200/dead/1/3/2", k, mem_req, mem_addr, mem_wdata, mem_rw, mem_mask, mem_mmumod);
      end
      step();
    end
    data_req = 1'b0; mem_lock = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h200 || mem_req !== 1'b1) begin errors++; $display("FAIL lock_release: got req=%b addr=%h expected 1/200", mem_req, mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lock_issued_once: got %b expected 0", mem_req); end
    mem_valid = 1'b1; mem_pf = 1'b1; mem_rdata = 32'h55;
    step();
    checks++; if (data_valid !== 1'b1 || data_pf !== 1'b1 || data_rdata !== 32'h55) begin errors++; $display("FAIL lock_resp: got v=%b pf=%b d=%h expected 1/1/55", data_valid, data_pf, data_rdata); end
    mem_valid = 1'b0; mem_pf = 1'b0;
    step();
    checks++; if (data_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL lock_after: got v=%b err=%b expected 0/0", data_valid, proto_err); end
    // the write issued exactly once, so a second response is a stray
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL lock_single_issue: got err=%b expected 1", proto_err); end
    $display("mem_lock: write 200/dead held and issued");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_protocol();
    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b expected 0", proto_err); end
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    checks++; if (proto_err !== 1'b1 || data_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL proto_set: got err=%b dv=%b iv=%b expected 1/0/0", proto_err, data_valid, if_valid); end
    step();
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
    rst = 1'b1;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset: got %b expected 0", proto_err); end
    step();
    rst = 1'b0;
    // reset in the middle of a stalled request drops it
    data_req = 1'b1; data_addr = 32'h400; mem_lock = 1'b1;
    step();
    data_req = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL proto_staged: got %b expected 1", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL proto_mid_reset: got %b expected 0", mem_req); end
    step();
    rst = 1'b0; mem_lock = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL proto_dropped: got %b expected 0", mem_req); end
    $display("protocol: stray response flagged");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_if_stream();
    test_starvation();
    test_full();
    test_flush();
    test_flush_staged();
    test_mem_lock();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
